// File: rtl/uart_avm_bridge.sv
// Serial command bridge: 8N1 UART framed read/write commands driving an Avalon-MM master.
// Responses (read data, 0xA5 ack, 0xEE error) are serialised back out on TX.
module uart_avm_bridge #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int AVM_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 65536
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX,
  output logic                TX,
  output logic                busy,
  output logic                error,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int AB    = ADDR_W / 8;
  localparam int DB    = DATA_W / 8;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AT_W  = $clog2(AVM_TIMEOUT + 1);
  localparam int FT_W  = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WR, S_RD, S_TXD, S_ACK, S_ERR
  } state_t;

  state_t state, state_nxt;

  // ---------------- UART receiver ----------------
  logic             rx_m, rx_s;
  logic             rx_busy;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_idx;
  logic [7:0]       rx_sh;
  logic [7:0]       rx_byte;
  logic             rx_full;
  logic             rx_take;
  logic             rx_vld;
  logic             ovr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // rx_idx 0 is the start bit, 1..8 data bits, 9 the stop bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_byte <= '0;
      rx_full <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (rx_take) rx_full <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_idx  <= '0;
        end
      end else if (rx_idx == 4'd0) begin
        if (rx_cnt == CNT_W'(HALF - 1)) begin
          rx_cnt <= '0;
          if (rx_s) rx_busy <= 1'b0;
          else      rx_idx  <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
        rx_cnt <= '0;
        if (rx_idx == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s) begin
            if (rx_full && !rx_take) begin
              ovr <= 1'b1;
            end else begin
              rx_byte <= rx_sh;
              rx_full <= 1'b1;
            end
          end
        end else begin
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_idx <= rx_idx + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // Every state either consumes or discards a held byte in the cycle it appears.
  assign rx_vld  = rx_full;
  assign rx_take = rx_full;

  // ---------------- UART transmitter ----------------
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [9:0]       tx_sh;
  logic [3:0]       tx_left;
  logic [CNT_W-1:0] tx_cnt;
  logic             tx_idle;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_sh   <= '1;
      tx_left <= '0;
      tx_cnt  <= '0;
    end else if (tx_left == 4'd0) begin
      if (tx_start) begin
        tx_sh   <= {1'b1, tx_data, 1'b0};
        tx_left <= 4'd10;
        tx_cnt  <= '0;
      end
    end else if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
      tx_cnt  <= '0;
      tx_sh   <= {1'b1, tx_sh[9:1]};
      tx_left <= tx_left - 4'd1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign tx_idle = (tx_left == 4'd0);
  assign TX      = tx_sh[0];

  // ---------------- Command datapath ----------------
  logic              is_rd;
  logic [4:0]        words_left;
  logic [2:0]        bcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [AT_W-1:0]   at_cnt;
  logic [FT_W-1:0]   ft_cnt;
  logic              error_q;
  logic              in_frame, in_avm;
  logic              ft_exp, at_exp, avm_done;
  logic              last_ab, last_db, last_word;

  assign in_frame  = (state == S_ADDR) || (state == S_WDATA);
  assign in_avm    = (state == S_RD) || (state == S_WR);
  assign ft_exp    = in_frame && !rx_vld && (ft_cnt == FT_W'(FRAME_TIMEOUT - 1));
  assign at_exp    = in_avm && avm_waitrequest && (at_cnt == AT_W'(AVM_TIMEOUT - 1));
  assign avm_done  = in_avm && !avm_waitrequest;
  assign last_ab   = (bcnt == 3'(AB - 1));
  assign last_db   = (bcnt == 3'(DB - 1));
  assign last_word = (words_left == 5'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      is_rd      <= 1'b0;
      words_left <= '0;
      bcnt       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      at_cnt     <= '0;
      ft_cnt     <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= ovr | ft_exp | at_exp;
      ft_cnt  <= (in_frame && !rx_vld) ? ft_cnt + 1'b1 : '0;
      at_cnt  <= (in_avm && avm_waitrequest) ? at_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (rx_vld) begin
          is_rd      <= rx_byte[7];
          words_left <= {1'b0, rx_byte[3:0]} + 5'd1;
          bcnt       <= '0;
        end
        S_ADDR: if (rx_vld) begin
          addr_q <= (addr_q >> 8) | (ADDR_W'(rx_byte) << (ADDR_W - 8));
          bcnt   <= last_ab ? 3'd0 : bcnt + 3'd1;
        end
        S_WDATA: if (rx_vld) begin
          wdata_q <= (wdata_q >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));
          bcnt    <= last_db ? 3'd0 : bcnt + 3'd1;
        end
        S_WR: if (avm_done) begin
          addr_q     <= addr_q + ADDR_W'(DB);
          words_left <= words_left - 5'd1;
        end
        S_RD: if (avm_done) begin
          rdata_q <= avm_readdata;
          addr_q  <= addr_q + ADDR_W'(DB);
        end
        S_TXD: if (tx_idle) begin
          rdata_q <= rdata_q >> 8;
          bcnt    <= last_db ? 3'd0 : bcnt + 3'd1;
          if (last_db) words_left <= words_left - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- Control FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rx_vld) state_nxt = S_ADDR;
      S_ADDR: begin
        if (ft_exp)                  state_nxt = S_IDLE;
        else if (rx_vld && last_ab)  state_nxt = is_rd ? S_RD : S_WDATA;
      end
      S_WDATA: begin
        if (ft_exp)                  state_nxt = S_IDLE;
        else if (rx_vld && last_db)  state_nxt = S_WR;
      end
      S_WR: begin
        if (at_exp)                  state_nxt = S_ERR;
        else if (avm_done)           state_nxt = last_word ? S_ACK : S_WDATA;
      end
      S_RD: begin
        if (at_exp)                  state_nxt = S_ERR;
        else if (avm_done)           state_nxt = S_TXD;
      end
      S_TXD:   if (tx_idle && last_db) state_nxt = last_word ? S_IDLE : S_RD;
      S_ACK:   if (tx_idle) state_nxt = S_IDLE;
      S_ERR:   if (tx_idle) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start  = 1'b0;
    tx_data   = rdata_q[7:0];
    avm_read  = (state == S_RD);
    avm_write = (state == S_WR);
    busy      = (state != S_IDLE);
    case (state)
      S_TXD: tx_start = tx_idle;
      S_ACK: begin
        tx_start = tx_idle;
        tx_data  = 8'hA5;
      end
      S_ERR: begin
        tx_start = tx_idle;
        tx_data  = 8'hEE;
      end
      default: ;
    endcase
  end

  assign error          = error_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = '1;

endmodule

// File: tb/tb_uart_avm_bridge.sv
// Randomised scoreboard bench for uart_avm_bridge: a command-level model predicts Avalon
// accesses and TX bytes; independent monitors on the bus and the TX line pop and compare.
module tb_uart_avm_bridge;
  localparam int CPB = 4;
  localparam int AVT = 8;
  localparam int FT  = 300;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RX  = 1'b1;
  logic        TX, busy, error;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b1;

  always #5 CLK = ~CLK;

  uart_avm_bridge #(
    .CLKS_PER_BIT(CPB), .ADDR_W(32), .DATA_W(32), .AVM_TIMEOUT(AVT), .FRAME_TIMEOUT(FT)
  ) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .TX(TX), .busy(busy), .error(error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } av_t;

  int          checks = 0, errors = 0;
  av_t         exp_av[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] mdl_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] wbuf [16];
  int          exp_err = 0, err_seen = 0, stall_seen = 0, stall_left = 0;
  bit          force_stall = 1'b0, tx_mon_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return dflt(a);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 4);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (CPB + gap) @(negedge CLK);
  endtask

  // Reference model: a command is N word accesses at a, a+4, ... (mod 2^32).
  task automatic issue(input bit rd, input int n, input logic [31:0] a, input logic [2:0] hi);
    logic [7:0]  cmd;
    logic [31:0] ai, d;
    av_t         e;
    cmd = {rd, hi, 4'(n - 1)};
    for (int i = 0; i < n; i++) begin
      ai     = a + 32'(4 * i);
      e.we   = !rd;
      e.addr = ai;
      e.data = rd ? 32'h0 : wbuf[i];
      exp_av.push_back(e);
      if (rd) begin
        d = mdl_rd(ai);
        for (int k = 0; k < 4; k++) exp_tx.push_back(d[8*k +: 8]);
      end else begin
        mdl_mem[ai] = wbuf[i];
      end
    end
    if (!rd) exp_tx.push_back(8'hA5);
    send_byte(cmd);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    if (!rd)
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) send_byte(wbuf[i][8*k +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 20000;
    while ((exp_tx.size() != 0 || exp_av.size() != 0 || busy || tx_mon_busy) && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d tx / %0d avalon pending, required 0", tag, exp_tx.size(), exp_av.size());
      exp_tx.delete();
      exp_av.delete();
    end
    repeat (CPB * 12) @(negedge CLK);
    check({tag, "_err_count"}, err_seen, exp_err);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Avalon slave with random stall; completions are checked against the model's queue.
  initial begin
    av_t e;
    forever begin
      @(negedge CLK);
      if (avm_read || avm_write) begin
        if (force_stall) begin
          avm_waitrequest = 1'b1;
          stall_seen++;
        end else if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          if (exp_av.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL av_unexpected: got access at %08h, required none", avm_address);
          end else begin
            e = exp_av.pop_front();
            check("av_write", avm_write, e.we);
            check("av_addr", avm_address, e.addr);
            check("av_be", avm_byteenable, 4'hF);
            if (e.we) check("av_wdata", avm_writedata, e.data);
          end
          if (avm_write) slv_mem[avm_address] = avm_writedata;
          else avm_readdata = slv_mem.exists(avm_address) ? slv_mem[avm_address] : dflt(avm_address);
          stall_left = $urandom_range(0, 3);
        end
      end else begin
        avm_waitrequest = 1'b1;
      end
    end
  end

  // TX line decoder.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge CLK);
      if (!RST && TX == 1'b0) begin
        tx_mon_busy = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        check("tx_start_bit", TX, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b = {TX, b[7:1]};
        end
        repeat (CPB) @(negedge CLK);
        check("tx_stop_bit", TX, 1'b1);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got byte %02h, required none", b);
        end else begin
          check("tx_byte", b, exp_tx.pop_front());
        end
        tx_mon_busy = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (error) err_seen++;
  end

  initial begin
    int budget;
    repeat (3) @(negedge CLK);
    check("rst_tx", TX, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_read", avm_read, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_addr", avm_address, 32'h0);
    check("rst_wdata", avm_writedata, 32'h0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    wbuf[0] = 32'hDEAD_BEEF;
    issue(1'b0, 1, 32'h0000_0010, 3'd0);
    wait_idle("single_write");

    mdl_mem[32'h100] = 32'h1122_3344;  slv_mem[32'h100] = 32'h1122_3344;
    mdl_mem[32'h104] = 32'h5566_7788;  slv_mem[32'h104] = 32'h5566_7788;
    issue(1'b1, 2, 32'h0000_0100, 3'd0);
    wait_idle("burst_read");

    issue(1'b1, 2, 32'hFFFF_FFFC, 3'd0);
    wait_idle("wrap_read");

    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    issue(1'b0, 16, 32'h0000_2000, 3'd5);
    wait_idle("write16");
    issue(1'b1, 16, 32'h0000_2000, 3'd2);
    wait_idle("read16");

    force_stall = 1'b1;
    stall_seen  = 0;
    exp_tx.push_back(8'hEE);
    exp_err++;
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(8'h40 >> (8 * k));
    for (int k = 0; k < 4; k++) send_byte(8'h5A);
    wait_idle("avm_timeout");
    check("timeout_strobe_cycles", stall_seen, AVT);
    force_stall = 1'b0;

    send_byte(8'h00);
    send_byte(8'h10);
    exp_err++;
    repeat (FT + 100) @(negedge CLK);
    wait_idle("frame_timeout");

    RX = 1'b0;
    @(negedge CLK);
    RX = 1'b1;
    repeat (60) @(negedge CLK);
    check("glitch_busy", busy, 1'b0);
    wait_idle("glitch");

    for (int t = 0; t < 14; t++) begin
      logic [31:0] a;
      int          n;
      bit          rd;
      case ($urandom_range(0, 3))
        0: a = 32'h0000_0010;
        1: a = 32'h0000_2004;
        2: a = 32'hFFFF_FFF8;
        default: a = $urandom;
      endcase
      n  = $urandom_range(1, 4);
      rd = $urandom_range(0, 1) == 1;
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      issue(rd, n, a, 3'($urandom));
      wait_idle("random");
    end

    force_stall = 1'b1;
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(8'h80);
    for (int k = 0; k < 3; k++) send_byte(8'h33);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = 1'b1;
      repeat (CPB) @(negedge CLK);
    end
    RX = 1'b1;
    budget = 200;
    while (!avm_write && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    check("rst_mid_write_seen", avm_write, 1'b1);
    RST = 1'b1;
    #1;
    check("rst_mid_write", avm_write, 1'b0);
    check("rst_mid_tx", TX, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_addr", avm_address, 32'h0);
    force_stall = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    wait_idle("post_reset");

    for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
    issue(1'b0, 2, 32'h0000_3000, 3'd7);
    wait_idle("post_reset_write");
    issue(1'b1, 2, 32'h0000_3000, 3'd1);
    wait_idle("post_reset_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "global timeout");
  end
endmodule
